// File: rtl/float_pkg.sv
// Shared types and width helpers for the float adder front end.
// Width helpers are functions so parameterised modules can derive W/MW from their own parameters.
package float_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_SUBNORMAL,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W:0]   mant;
    } unpacked_fp_t;

    function automatic int fp_width(input int ew, input int mw);
        return ew + mw + 1;
    endfunction

    function automatic int mant_width(input int mw);
        return mw + 4;
    endfunction

    // Canonical quiet NaN: positive, exponent all ones, only the fraction MSB set.
    function automatic logic [127:0] qnan_bits(input int ew, input int mw);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < ew; i++) begin
            v[mw+i] = 1'b1;
        end
        v[mw-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/float_shift_sticky.sv
// Combinational right shifter that folds every bit shifted out into the result LSB (sticky).
module float_shift_sticky #(
    parameter int DATA_W  = 27,
    parameter int SHIFT_W = 8
) (
    input  logic [DATA_W-1:0]  data_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [DATA_W-1:0]  data_o
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] lost_mask;

    always_comb begin
        shifted   = data_i >> shift_i;
        lost_mask = ~({DATA_W{1'b1}} << shift_i);
        if (32'(shift_i) >= DATA_W) begin
            data_o = {{(DATA_W-1){1'b0}}, |data_i};
        end else begin
            data_o = {shifted[DATA_W-1:1], shifted[0] | (|(data_i & lost_mask))};
        end
    end

endmodule

// File: rtl/float_align_stage.sv
// Two-stage operand alignment front end for the float adder (classify/swap, then shift with sticky).
// Define FLOAT_ALIGN_DENORM_EN to keep subnormals; otherwise they are flushed to signed zero.
module float_align_stage
    import float_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    localparam int W  = fp_width(EXPONENT_WIDTH, MANTISSA_WIDTH),
    localparam int MW = mant_width(MANTISSA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              A,
    input  logic [W-1:0]              B,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_big_sign,
    output logic                      out_eff_sub,
    output logic [EXPONENT_WIDTH-1:0] out_exponent,
    output logic [MW-1:0]             out_big_mant,
    output logic [MW-1:0]             out_small_mant,
    output logic                      out_special,
    output logic [W-1:0]              out_special_value
);

    localparam int E = EXPONENT_WIDTH;
    localparam int M = MANTISSA_WIDTH;
    localparam logic [W-1:0] QNAN = W'(qnan_bits(E, M));

    function automatic fp_class_t classify(input logic [E-1:0] e, input logic [M-1:0] f);
        if (&e)        return (|f) ? FP_NAN : FP_INF;
        if (e == '0)   return (|f) ? FP_SUBNORMAL : FP_ZERO;
        return FP_NORMAL;
    endfunction

    // {effective exponent, hidden, fraction}: doubles as the magnitude compare key.
    function automatic logic [E+M:0] eff_key(input fp_class_t c, input logic [E-1:0] e,
                                             input logic [M-1:0] f);
        case (c)
            FP_ZERO:      return '0;
`ifdef FLOAT_ALIGN_DENORM_EN
            FP_SUBNORMAL: return {E'(1), 1'b0, f};
`else
            FP_SUBNORMAL: return '0;
`endif
            default:      return {e, 1'b1, f};
        endcase
    endfunction

    fp_class_t      cls_a, cls_b;
    logic [E+M:0]   key_a, key_b, key_big, key_small;
    logic           a_is_big;
    logic           s2_ready, s1_advance;
    logic           s1_valid_d, s2_valid_d;

    logic           s1_big_sign_d, s1_eff_sub_d, s1_special_d;
    logic [E-1:0]   s1_exp_d, s1_diff_d;
    logic [M:0]     s1_big_mant_d, s1_small_mant_d;
    logic [W-1:0]   s1_special_value_d;

    logic           s1_valid_q, s1_big_sign_q, s1_eff_sub_q, s1_special_q;
    logic [E-1:0]   s1_exp_q, s1_diff_q;
    logic [M:0]     s1_big_mant_q, s1_small_mant_q;
    logic [W-1:0]   s1_special_value_q;

    logic           s2_valid_q, s2_big_sign_q, s2_eff_sub_q, s2_special_q;
    logic [E-1:0]   s2_exp_q;
    logic [MW-1:0]  s2_big_mant_q, s2_small_mant_q, small_shifted;
    logic [W-1:0]   s2_special_value_q;

    always_comb begin
        cls_a     = classify(A[W-2:M], A[M-1:0]);
        cls_b     = classify(B[W-2:M], B[M-1:0]);
        key_a     = eff_key(cls_a, A[W-2:M], A[M-1:0]);
        key_b     = eff_key(cls_b, B[W-2:M], B[M-1:0]);
        a_is_big  = !(key_b > key_a);
        key_big   = a_is_big ? key_a : key_b;
        key_small = a_is_big ? key_b : key_a;

        s1_big_sign_d   = a_is_big ? A[W-1] : B[W-1];
        s1_eff_sub_d    = A[W-1] ^ B[W-1];
        s1_exp_d        = key_big[E+M:M+1];
        s1_big_mant_d   = key_big[M:0];
        s1_small_mant_d = key_small[M:0];
        s1_diff_d       = key_big[E+M:M+1] - key_small[E+M:M+1];

        s1_special_d       = 1'b1;
        s1_special_value_d = QNAN;
        if (cls_a == FP_NAN || cls_b == FP_NAN) begin
            s1_special_value_d = QNAN;
        end else if (cls_a == FP_INF && cls_b == FP_INF) begin
            s1_special_value_d = (A[W-1] != B[W-1]) ? QNAN : A;
        end else if (cls_a == FP_INF) begin
            s1_special_value_d = A;
        end else if (cls_b == FP_INF) begin
            s1_special_value_d = B;
        end else begin
            s1_special_d       = 1'b0;
            s1_special_value_d = '0;
        end
    end

    assign s2_ready   = !s2_valid_q || out_ready;
    assign s1_advance = !s1_valid_q || s2_ready;
    assign in_ready   = !reset && s1_advance;
    assign s1_valid_d = s1_advance ? in_valid : s1_valid_q;
    assign s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q         <= 1'b0;
            s1_big_sign_q      <= 1'b0;
            s1_eff_sub_q       <= 1'b0;
            s1_special_q       <= 1'b0;
            s1_exp_q           <= '0;
            s1_diff_q          <= '0;
            s1_big_mant_q      <= '0;
            s1_small_mant_q    <= '0;
            s1_special_value_q <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_advance && in_valid) begin
                s1_big_sign_q      <= s1_big_sign_d;
                s1_eff_sub_q       <= s1_eff_sub_d;
                s1_special_q       <= s1_special_d;
                s1_exp_q           <= s1_exp_d;
                s1_diff_q          <= s1_diff_d;
                s1_big_mant_q      <= s1_big_mant_d;
                s1_small_mant_q    <= s1_small_mant_d;
                s1_special_value_q <= s1_special_value_d;
            end
        end
    end

    float_shift_sticky #(
        .DATA_W  (MW),
        .SHIFT_W (E)
    ) u_shift (
        .data_i  ({s1_small_mant_q, 3'b000}),
        .shift_i (s1_diff_q),
        .data_o  (small_shifted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid_q         <= 1'b0;
            s2_big_sign_q      <= 1'b0;
            s2_eff_sub_q       <= 1'b0;
            s2_special_q       <= 1'b0;
            s2_exp_q           <= '0;
            s2_big_mant_q      <= '0;
            s2_small_mant_q    <= '0;
            s2_special_value_q <= '0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_ready && s1_valid_q) begin
                s2_big_sign_q      <= s1_big_sign_q;
                s2_eff_sub_q       <= s1_eff_sub_q;
                s2_special_q       <= s1_special_q;
                s2_exp_q           <= s1_exp_q;
                s2_big_mant_q      <= {s1_big_mant_q, 3'b000};
                s2_small_mant_q    <= small_shifted;
                s2_special_value_q <= s1_special_value_q;
            end
        end
    end

    assign out_valid         = s2_valid_q;
    assign out_big_sign      = s2_big_sign_q;
    assign out_eff_sub       = s2_eff_sub_q;
    assign out_exponent      = s2_exp_q;
    assign out_big_mant      = s2_big_mant_q;
    assign out_small_mant    = s2_small_mant_q;
    assign out_special       = s2_special_q;
    assign out_special_value = s2_special_value_q;

endmodule

// File: tb/tb_float_align_stage.sv
// Directed bench for float_align_stage in single precision with hand-computed expectations.
module tb_float_align_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B;
    logic        out_valid;
    logic        out_ready;
    logic        out_big_sign;
    logic        out_eff_sub;
    logic [7:0]  out_exponent;
    logic [26:0] out_big_mant;
    logic [26:0] out_small_mant;
    logic        out_special;
    logic [31:0] out_special_value;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    float_align_stage #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .A                 (A),
        .B                 (B),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_big_sign      (out_big_sign),
        .out_eff_sub       (out_eff_sub),
        .out_exponent      (out_exponent),
        .out_big_mant      (out_big_mant),
        .out_small_mant    (out_small_mant),
        .out_special       (out_special),
        .out_special_value (out_special_value)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair with out_ready=1 and land on the cycle its result is visible.
    task automatic push_and_wait(input logic [31:0] a, input logic [31:0] b);
        A = a;
        B = b;
        in_valid = 1'b1;
        chk("push_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("lat1_out_valid", out_valid, 0);
        step();
        chk("lat2_out_valid", out_valid, 1);
    endtask

    logic [31:0] vb [4];
    int          idx, ocnt;
    logic        acc_in, acc_out;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_exponent", out_exponent, 0);
        chk("rst_small_mant", out_small_mant, 0);
        chk("rst_special_value", out_special_value, 0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        // 1.0 + 2.0
        push_and_wait(32'h3F800000, 32'h40000000);
        chk("t1_exponent", out_exponent, 8'h80);
        chk("t1_big_mant", out_big_mant, 27'h4000000);
        chk("t1_small_mant", out_small_mant, 27'h2000000);
        chk("t1_eff_sub", out_eff_sub, 0);
        chk("t1_big_sign", out_big_sign, 0);
        chk("t1_special", out_special, 0);
        chk("t1_special_value", out_special_value, 0);

        // diff 126: everything collapses into sticky
        push_and_wait(32'h3F800000, 32'h00800000);
        chk("t2_small_mant", out_small_mant, 27'h0000001);
        chk("t2_exponent", out_exponent, 8'h7F);
        chk("t2_big_mant", out_big_mant, 27'h4000000);

        // diff 23 with a set fraction LSB lost into sticky
        push_and_wait(32'h4B000000, 32'h3F800001);
        chk("t_d23_small", out_small_mant, 27'h0000009);
        chk("t_d23_exp", out_exponent, 8'h96);

        // diff 25, nothing lost
        push_and_wait(32'h4C000000, 32'h3FC00000);
        chk("t_d25_small", out_small_mant, 27'h0000003);

        // diff 26, exact edge of the shifter width
        push_and_wait(32'h4C800000, 32'h3F800000);
        chk("t_d26_small", out_small_mant, 27'h0000001);

        // -2.0 + 1.0: B is smaller, big sign negative
        push_and_wait(32'hC0000000, 32'h3F800000);
        chk("t_neg_big_sign", out_big_sign, 1);
        chk("t_neg_eff_sub", out_eff_sub, 1);
        chk("t_neg_small", out_small_mant, 27'h2000000);

        // equal magnitudes: A stays big
        push_and_wait(32'h3F800000, 32'hBF800000);
        chk("t_tie_big_sign", out_big_sign, 0);
        chk("t_tie_small", out_small_mant, 27'h4000000);

        push_and_wait(32'h7FC00001, 32'h3F800000);
        chk("t3_nan_special", out_special, 1);
        chk("t3_nan_value", out_special_value, 32'h7FC00000);

        push_and_wait(32'h7F800000, 32'hFF800000);
        chk("t3_infinf_special", out_special, 1);
        chk("t3_infinf_value", out_special_value, 32'h7FC00000);

        push_and_wait(32'h3F800000, 32'hFF800000);
        chk("t3_inf_fin_value", out_special_value, 32'hFF800000);

        push_and_wait(32'h00000002, 32'h00000001);
`ifdef FLOAT_ALIGN_DENORM_EN
        chk("t6_exponent", out_exponent, 8'h01);
        chk("t6_big_mant", out_big_mant, 27'h0000010);
        chk("t6_small_mant", out_small_mant, 27'h0000008);
`else
        chk("t6_exponent", out_exponent, 8'h00);
        chk("t6_big_mant", out_big_mant, 27'h0000000);
        chk("t6_small_mant", out_small_mant, 27'h0000000);
`endif

        // Back-pressure: four back-to-back inputs, out_ready low for the first three cycles
        step();
        chk("bp_empty", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            vb[i] = 32'h3F800000 - ((i + 1) << 23);
        end
        idx  = 0;
        ocnt = 0;
        for (int cyc = 0; cyc < 20 && ocnt < 4; cyc++) begin
            out_ready = (cyc >= 3);
            in_valid  = (idx < 4);
            A         = 32'h3F800000;
            B         = (idx < 4) ? vb[idx] : 32'h0;
            #1;
            if (cyc == 2) chk("bp_in_ready_low", in_ready, 0);
            if (cyc == 3) chk("bp_in_ready_high", in_ready, 1);
            if (out_valid) begin
                chk("bp_order_small", out_small_mant, 27'h4000000 >> (ocnt + 1));
                chk("bp_exponent", out_exponent, 8'h7F);
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            step();
            if (acc_in)  idx++;
            if (acc_out) ocnt++;
        end
        in_valid = 1'b0;
        chk("bp_all_in", idx, 4);
        chk("bp_all_out", ocnt, 4);

        // Reset with both stages occupied
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A         = 32'h3F800000;
        B         = 32'h40000000;
        step();
        step();
        in_valid = 1'b0;
        chk("t5_pre_out_valid", out_valid, 1);
        chk("t5_pre_in_ready", in_ready, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_small", out_small_mant, 0);
        step();
        reset = 1'b0;
        #1;
        chk("t5_rel_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t5_no_stale", out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
